dma_write_master: RTL and testbench
===================================

# dma_write_master

AXI4 write master for the DMA datapath: pops words from the read/write data FIFO and writes them to destination memory as INCR bursts over AXI4 AW/W/B. It sits directly downstream of `Read_Master` (via the shared FIFO) and is the write half of the DMA copy engine. A single command moves `i_total_len` bytes starting at `i_dst_addr`, then pulses `o_write_done`.

## Interface
- `C_M_AXI_ADDR_WIDTH`, 32, AXI address width.
- `C_M_AXI_DATA_WIDTH`, 32, AXI data width. Only 32 is supported.
- `C_MAX_BURST_LEN`, 16, maximum beats per burst (1..256).

Ports:
- `clk` in 1 — single clock.
- `reset_n` in 1 — reset, asynchronous assert, active-low.
- `i_start` in 1 — command strobe; sampled only in IDLE.
- `i_dst_addr` in 32 — destination byte address; must be word-aligned.
- `i_total_len` in 32 — byte count; must be a multiple of 4.
- `o_write_done` out 1 — one-cycle pulse when the command completes.
- `o_busy` out 1 — high while state is not IDLE.
- `i_fifo_empty` in 1 — FIFO empty flag.
- `i_w_data` in 32 — FIFO head word; first-word-fall-through, valid whenever `!i_fifo_empty`.
- `o_fifo_pop` out 1 — pops the FIFO head.
- `m_axi_awaddr` out 32, `m_axi_awlen` out 8, `m_axi_awsize` out 3, `m_axi_awburst` out 2, `m_axi_awvalid` out 1, `m_axi_awready` in 1 — AW channel.
- `m_axi_wdata` out 32, `m_axi_wstrb` out 4, `m_axi_wlast` out 1, `m_axi_wvalid` out 1, `m_axi_wready` in 1 — W channel.
- `m_axi_bresp` in 2, `m_axi_bvalid` in 1, `m_axi_bready` out 1 — B channel.

## Operation
- FSM states: IDLE, AW, W, B, DONE.
- IDLE, `i_start`=1:
  - Latch the address into `cur_addr` and `i_total_len>>2` into `rem_words` (30 bits).
  - If `rem_words`==0, go to DONE with no AXI traffic. Otherwise go to AW.
- AW state:
  - `awlen` = beats−1, where beats = min(`rem_words`, `C_MAX_BURST_LEN`, words remaining to the next 4 KB boundary, i.e. (4096−`cur_addr[11:0]`)>>2).
  - `awsize`=3'b010 and `awburst`=2'b01, constant.
  - On `awvalid`&&`awready`, latch beats and go to W.
- W state:
  - `wvalid` = `!i_fifo_empty`.
  - `wdata` = `i_w_data`, combinational pass-through.
  - `wstrb` = 4'hF.
  - `wlast` = (`beat_cnt` == latched `awlen`).
  - `o_fifo_pop` = `wvalid && wready`; each pop increments `beat_cnt`.
  - On the pop with `wlast` high, go to B.
- B state:
  - `bready`=1.
  - On `bvalid`: `cur_addr += beats*4`, `rem_words -= beats`.
  - Then go to DONE if `rem_words` reaches 0, else AW.
- DONE: `o_write_done`=1 for exactly one cycle, then IDLE.
- W is never issued before the AW handshake of the same burst. Only one burst is outstanding at a time.
- `i_start` is ignored outside IDLE.
- `i_dst_addr` and `i_total_len` are sampled only on accepted `i_start`.

## Timing
- Reset values: all outputs 0, except `m_axi_awsize`=3'b010, `m_axi_awburst`=2'b01, `m_axi_wstrb`=4'hF. State = IDLE, counters = 0.
- `reset_n` low mid-burst: immediately return to IDLE with all valids low. The burst is abandoned; FIFO contents are not flushed.
- `awvalid` is registered: it rises the cycle after entering AW and stays stable with `awaddr`/`awlen` until `awready`. It drops the cycle after the handshake.
- `awready` high before `awvalid` is legal and is ignored.
- Latency: `i_start` to first `awvalid` = 2 cycles.
- Last B handshake to `o_write_done` = 1 cycle (DONE is a registered state).
- `wvalid` may toggle with the FIFO level. Once `wvalid` is high with `wready` low, FIFO data is stable because nothing is popped.
- `i_total_len`=0: `o_write_done` pulses 2 cycles after `i_start`.
- Throughput: one beat per cycle when the FIFO is non-empty and `wready`=1.

## Configuration
- `DMA_WR_BRESP_CHECK_EN` defined:
  - Adds output `o_wr_err` (1 bit, reset 0).
  - `o_wr_err` is set sticky when `bvalid` && `bresp`!=2'b00, and cleared on the next accepted `i_start`.
  - The transfer still runs to completion.
- `DMA_WR_BRESP_CHECK_EN` not defined: the port is absent and `bresp` is ignored.

## Structure
- Shared package `dma_pkg`:
  - state encoding `wm_state_t` (IDLE/AW/W/B/DONE);
  - constants `AXI_BURST_INCR`=2'b01, `AXI_SIZE_4B`=3'b010, `AXI_RESP_OKAY`=2'b00, `AXI_4K_BYTES`=4096.
- Sub-module `dma_burst_calc`: combinational beats computation (min of remaining words, max burst, 4 KB boundary) plus `awlen` derivation. It is reused by `Read_Master`.

## Test plan
- **Basic:** addr 0xC000_0000, len 64, FIFO preloaded with 16 words, always-ready slave.
  - Required: one AW with `awlen`=15, 16 beats, `wlast` on beat 16, `o_write_done` 1 cycle after B. Memory matches the FIFO data.
- **Multi-burst:** len 65536 with a mem-file-driven FIFO.
  - Required: 1024 bursts of 16 beats, byte-exact dump, single `o_write_done`.
- **4 KB split:** addr 0xC000_0FF0, len 64.
  - Required: bursts of `awlen`=3 (addr 0xC000_0FF0), then `awlen`=11 (addr 0xC000_1000).
- **Backpressure:** random `i_fifo_empty` and random `wready`/`awready`/`bvalid` delays.
  - Required: no pop while `wready`=0, no data loss or duplication, `awaddr`/`awlen` stable while `awvalid`.
- **Corners:** len 0 → done 2 cycles later with no AXI activity. `reset_n` pulsed mid-W → all valids 0 and IDLE; a new command then completes.
- **`DMA_WR_BRESP_CHECK_EN`:** `bresp`=2'b10 on burst 2 of 3.
  - Required: `o_wr_err`=1 and stays 1, all 3 bursts still complete, `o_wr_err` clears on the next `i_start`.

Source files
------------

// File: rtl/dma_pkg.sv
// -----------------------------------------------------------------------------
// dma_pkg
// Shared definitions for the DMA copy engine (read and write masters).
//   wm_state_t      : write-master FSM encoding (IDLE/AW/W/B/DONE)
//   AXI_BURST_INCR  : AXI4 INCR burst type
//   AXI_SIZE_4B     : AXI4 4-byte beat size
//   AXI_RESP_OKAY   : AXI4 OKAY response code
//   AXI_4K_BYTES    : AXI4 burst page size (bursts must not cross it)
// -----------------------------------------------------------------------------
package dma_pkg;

    typedef enum logic [2:0] {
        WM_IDLE = 3'd0,
        WM_AW   = 3'd1,
        WM_W    = 3'd2,
        WM_B    = 3'd3,
        WM_DONE = 3'd4
    } wm_state_t;

    localparam logic [1:0] AXI_BURST_INCR = 2'b01;
    localparam logic [2:0] AXI_SIZE_4B    = 3'b010;
    localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;
    localparam int         AXI_4K_BYTES   = 4096;

endpackage

// File: rtl/dma_burst_calc.sv
// -----------------------------------------------------------------------------
// dma_burst_calc
// Combinational burst sizing shared by the DMA read and write masters.
// beats = min(rem_words, MAX_BURST_LEN, words left before the next 4 KB page)
// Ports:
//   rem_words : words still to transfer (30 bits)
//   addr_lo   : low 12 bits of the current word-aligned byte address
//   beats     : beats for the next burst (1..256 when rem_words != 0)
//   awlen     : AXI length field, beats - 1
// -----------------------------------------------------------------------------
module dma_burst_calc
    import dma_pkg::*;
#(
    parameter int MAX_BURST_LEN = 16
) (
    input  logic [29:0] rem_words,
    input  logic [11:0] addr_lo,
    output logic [8:0]  beats,
    output logic [7:0]  awlen
);

    localparam logic [10:0] MAX_BEATS_W = 11'(MAX_BURST_LEN);
    localparam logic [8:0]  MAX_BEATS   = 9'(MAX_BURST_LEN);

    logic [10:0] words_to_4k_s;
    logic [8:0]  limit_s;

    // Words between the current address and the next 4 KB page (1..1024).
    assign words_to_4k_s = 11'((13'(AXI_4K_BYTES) - {1'b0, addr_lo}) >> 2);

    // Clamp to the page limit and maximum burst length, then to the words left.
    always_comb begin
        limit_s = MAX_BEATS;
        beats   = 9'd0;
        if (words_to_4k_s < MAX_BEATS_W) begin
            limit_s = words_to_4k_s[8:0];
        end else begin
            limit_s = MAX_BEATS;
        end
        if (rem_words < {21'd0, limit_s}) begin
            beats = rem_words[8:0];
        end else begin
            beats = limit_s;
        end
    end

    assign awlen = 8'(beats - 9'd1);

endmodule

// File: rtl/dma_write_master.sv
// -----------------------------------------------------------------------------
// dma_write_master
// AXI4 write master of the DMA copy engine. Pops words from the shared
// first-word-fall-through FIFO and writes i_total_len bytes starting at
// i_dst_addr as INCR bursts, one burst outstanding at a time, then pulses
// o_write_done for one cycle.
// Ports:
//   clk, reset_n              : clock, asynchronous active-low reset
//   i_start                   : command strobe, accepted only when idle
//   i_dst_addr, i_total_len   : word-aligned address, byte count (multiple of 4)
//   o_write_done, o_busy      : completion pulse, command in progress
//   i_fifo_empty, i_w_data    : FIFO status and head word
//   o_fifo_pop                : consume FIFO head (equals W handshake)
//   m_axi_aw*, m_axi_w*, m_axi_b* : AXI4 write address/data/response channels
//   o_wr_err (optional)       : sticky non-OKAY write response flag
// Build option: DMA_WR_BRESP_CHECK_EN adds o_wr_err; otherwise bresp is ignored.
// -----------------------------------------------------------------------------
module dma_write_master
    import dma_pkg::*;
#(
    parameter int C_M_AXI_ADDR_WIDTH = 32,
    parameter int C_M_AXI_DATA_WIDTH = 32,
    parameter int C_MAX_BURST_LEN    = 16
) (
    input  logic                            clk,
    input  logic                            reset_n,
    input  logic                            i_start,
    input  logic [C_M_AXI_ADDR_WIDTH-1:0]   i_dst_addr,
    input  logic [31:0]                     i_total_len,
    output logic                            o_write_done,
    output logic                            o_busy,
    input  logic                            i_fifo_empty,
    input  logic [C_M_AXI_DATA_WIDTH-1:0]   i_w_data,
    output logic                            o_fifo_pop,
    output logic [C_M_AXI_ADDR_WIDTH-1:0]   m_axi_awaddr,
    output logic [7:0]                      m_axi_awlen,
    output logic [2:0]                      m_axi_awsize,
    output logic [1:0]                      m_axi_awburst,
    output logic                            m_axi_awvalid,
    input  logic                            m_axi_awready,
    output logic [C_M_AXI_DATA_WIDTH-1:0]   m_axi_wdata,
    output logic [C_M_AXI_DATA_WIDTH/8-1:0] m_axi_wstrb,
    output logic                            m_axi_wlast,
    output logic                            m_axi_wvalid,
    input  logic                            m_axi_wready,
    input  logic [1:0]                      m_axi_bresp,
    input  logic                            m_axi_bvalid,
    output logic                            m_axi_bready
`ifdef DMA_WR_BRESP_CHECK_EN
    ,
    output logic                            o_wr_err
`endif
);

    wm_state_t                       state_r;
    wm_state_t                       next_state_s;
    logic [C_M_AXI_ADDR_WIDTH-1:0]   cur_addr_r;
    logic [29:0]                     rem_words_r;
    logic [29:0]                     rem_after_s;
    logic [8:0]                      beats_r;
    logic [7:0]                      beat_cnt_r;
    logic [C_M_AXI_ADDR_WIDTH-1:0]   awaddr_r;
    logic [7:0]                      awlen_r;
    logic                            awvalid_r;
    logic                            done_r;
    logic                            busy_r;
    logic [8:0]                      calc_beats_s;
    logic [7:0]                      calc_awlen_s;
    logic                            aw_hs_s;
    logic                            wvalid_s;
    logic                            w_hs_s;
    logic                            wlast_s;
    logic                            b_hs_s;
    logic                            start_s;
    logic                            len_unused_s;

    dma_burst_calc #(
        .MAX_BURST_LEN (C_MAX_BURST_LEN)
    ) u_burst_calc (
        .rem_words (rem_words_r),
        .addr_lo   (cur_addr_r[11:0]),
        .beats     (calc_beats_s),
        .awlen     (calc_awlen_s)
    );

    // The byte count is a multiple of 4, so its low bits carry no information.
    assign len_unused_s = ^i_total_len[1:0];

    assign start_s     = (state_r == WM_IDLE) && i_start;
    // awvalid is only seen by the handshake once it is actually driven.
    assign aw_hs_s     = awvalid_r && m_axi_awready;
    assign wvalid_s    = (state_r == WM_W) && !i_fifo_empty;
    assign w_hs_s      = wvalid_s && m_axi_wready;
    assign wlast_s     = (state_r == WM_W) && (beat_cnt_r == awlen_r);
    assign b_hs_s      = (state_r == WM_B) && m_axi_bvalid;
    assign rem_after_s = rem_words_r - {21'd0, beats_r};

    // Next-state logic. A zero-length command is recognised in AW on the
    // latched word count, so it reaches DONE without raising awvalid.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            WM_IDLE: begin
                if (i_start) begin
                    next_state_s = WM_AW;
                end else begin
                    next_state_s = WM_IDLE;
                end
            end
            WM_AW: begin
                if (rem_words_r == 30'd0) begin
                    next_state_s = WM_DONE;
                end else if (aw_hs_s) begin
                    next_state_s = WM_W;
                end else begin
                    next_state_s = WM_AW;
                end
            end
            WM_W: begin
                if (w_hs_s && wlast_s) begin
                    next_state_s = WM_B;
                end else begin
                    next_state_s = WM_W;
                end
            end
            WM_B: begin
                if (m_axi_bvalid) begin
                    if (rem_after_s == 30'd0) begin
                        next_state_s = WM_DONE;
                    end else begin
                        next_state_s = WM_AW;
                    end
                end else begin
                    next_state_s = WM_B;
                end
            end
            WM_DONE: begin
                next_state_s = WM_IDLE;
            end
            default: begin
                next_state_s = WM_IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r <= WM_IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Command progress: address and word count, advanced after each response.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cur_addr_r  <= '0;
            rem_words_r <= 30'd0;
        end else if (start_s) begin
            cur_addr_r  <= i_dst_addr;
            rem_words_r <= i_total_len[31:2];
        end else if (b_hs_s) begin
            cur_addr_r  <= cur_addr_r + C_M_AXI_ADDR_WIDTH'({beats_r, 2'b00});
            rem_words_r <= rem_after_s;
        end else begin
            cur_addr_r  <= cur_addr_r;
            rem_words_r <= rem_words_r;
        end
    end

    // AW channel: awvalid raised one cycle into AW with addr/len frozen until
    // the handshake, which also captures the burst size for the W phase.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            awvalid_r <= 1'b0;
            awaddr_r  <= '0;
            awlen_r   <= 8'd0;
            beats_r   <= 9'd0;
        end else if ((state_r == WM_AW) && !awvalid_r && (rem_words_r != 30'd0)) begin
            awvalid_r <= 1'b1;
            awaddr_r  <= cur_addr_r;
            awlen_r   <= calc_awlen_s;
            beats_r   <= calc_beats_s;
        end else if (aw_hs_s) begin
            awvalid_r <= 1'b0;
        end else begin
            awvalid_r <= awvalid_r;
        end
    end

    // Beat counter within the current burst.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            beat_cnt_r <= 8'd0;
        end else if (aw_hs_s) begin
            beat_cnt_r <= 8'd0;
        end else if (w_hs_s) begin
            beat_cnt_r <= beat_cnt_r + 8'd1;
        end else begin
            beat_cnt_r <= beat_cnt_r;
        end
    end

    // Status outputs, registered from the next state so they track the FSM.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            done_r <= 1'b0;
            busy_r <= 1'b0;
        end else begin
            done_r <= (next_state_s == WM_DONE);
            busy_r <= (next_state_s != WM_IDLE);
        end
    end

`ifdef DMA_WR_BRESP_CHECK_EN
    logic wr_err_r;

    // Sticky error on any non-OKAY response; a new command clears it.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_err_r <= 1'b0;
        end else if (start_s) begin
            wr_err_r <= 1'b0;
        end else if (b_hs_s && (m_axi_bresp != AXI_RESP_OKAY)) begin
            wr_err_r <= 1'b1;
        end else begin
            wr_err_r <= wr_err_r;
        end
    end

    assign o_wr_err = wr_err_r;
`else
    logic bresp_unused_s;
    assign bresp_unused_s = ^m_axi_bresp;
`endif

    assign o_write_done  = done_r;
    assign o_busy        = busy_r;
    assign o_fifo_pop    = w_hs_s;
    assign m_axi_awaddr  = awaddr_r;
    assign m_axi_awlen   = awlen_r;
    assign m_axi_awsize  = AXI_SIZE_4B;
    assign m_axi_awburst = AXI_BURST_INCR;
    assign m_axi_awvalid = awvalid_r;
    // FIFO head is passed straight through, but only presented during W.
    assign m_axi_wdata   = (state_r == WM_W) ? i_w_data : '0;
    assign m_axi_wstrb   = '1;
    assign m_axi_wlast   = wlast_s;
    assign m_axi_wvalid  = wvalid_s;
    assign m_axi_bready  = (state_r == WM_B);

endmodule

// File: tb/tb_dma_write_master.sv
// -----------------------------------------------------------------------------
// tb_dma_write_master
// Directed bench for dma_write_master: FIFO, AXI slave and scoreboard are
// modelled here; each comparison is an immediate assertion.
// -----------------------------------------------------------------------------
module tb_dma_write_master;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        i_start;
    logic [31:0] i_dst_addr;
    logic [31:0] i_total_len;
    logic        o_write_done;
    logic        o_busy;
    logic        i_fifo_empty;
    logic [31:0] i_w_data;
    logic        o_fifo_pop;
    logic [31:0] m_axi_awaddr;
    logic [7:0]  m_axi_awlen;
    logic [2:0]  m_axi_awsize;
    logic [1:0]  m_axi_awburst;
    logic        m_axi_awvalid;
    logic        m_axi_awready;
    logic [31:0] m_axi_wdata;
    logic [3:0]  m_axi_wstrb;
    logic        m_axi_wlast;
    logic        m_axi_wvalid;
    logic        m_axi_wready;
    logic [1:0]  m_axi_bresp;
    logic        m_axi_bvalid;
    logic        m_axi_bready;
    logic        o_wr_err;

    dma_write_master dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .i_start       (i_start),
        .i_dst_addr    (i_dst_addr),
        .i_total_len   (i_total_len),
        .o_write_done  (o_write_done),
        .o_busy        (o_busy),
        .i_fifo_empty  (i_fifo_empty),
        .i_w_data      (i_w_data),
        .o_fifo_pop    (o_fifo_pop),
        .m_axi_awaddr  (m_axi_awaddr),
        .m_axi_awlen   (m_axi_awlen),
        .m_axi_awsize  (m_axi_awsize),
        .m_axi_awburst (m_axi_awburst),
        .m_axi_awvalid (m_axi_awvalid),
        .m_axi_awready (m_axi_awready),
        .m_axi_wdata   (m_axi_wdata),
        .m_axi_wstrb   (m_axi_wstrb),
        .m_axi_wlast   (m_axi_wlast),
        .m_axi_wvalid  (m_axi_wvalid),
        .m_axi_wready  (m_axi_wready),
        .m_axi_bresp   (m_axi_bresp),
        .m_axi_bvalid  (m_axi_bvalid),
`ifdef DMA_WR_BRESP_CHECK_EN
        .o_wr_err      (o_wr_err),
`endif
        .m_axi_bready  (m_axi_bready)
    );

`ifndef DMA_WR_BRESP_CHECK_EN
    assign o_wr_err = 1'b0;
`endif

    always #5 clk = ~clk;

    int n_asserts = 0;
    int n_fail    = 0;
    int cyc       = 0;

    logic [31:0] fifo_q[$];
    logic [31:0] src_q[$];
    logic [31:0] exp_q[$];
    logic [31:0] got_q[$];
    logic [31:0] aw_addr_q[$];
    logic [7:0]  aw_len_q[$];

    bit          rnd_mode = 1'b0;
    bit          start_req = 1'b0;
    logic [31:0] cmd_addr, cmd_len;
    int          glitch_cyc = -1;
    int          err_burst = -1;

    int done_cnt, done_cyc, b_cyc, first_awv_cyc, start_cyc;
    int awvalid_seen, wvalid_seen, pop_err, aw_unstable_err, wlast_err, w_order_err;
    int b_count, beat;
    bit b_pend, aw_open, prev_aw_wait;
    logic [31:0] prev_awaddr;
    logic [7:0]  prev_awlen, cur_len;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // One clock: drive FIFO/slave inputs after the falling edge, then observe.
    task automatic step();
        @(negedge clk);
        if (src_q.size() > 0 && $urandom_range(0, 2) != 0) fifo_q.push_back(src_q.pop_front());
        i_start      = start_req || (cyc == glitch_cyc);
        i_dst_addr   = start_req ? cmd_addr : 32'hDEAD_BEE0;
        i_total_len  = start_req ? cmd_len  : 32'h0000_0040;
        i_fifo_empty = (fifo_q.size() == 0) || (rnd_mode && $urandom_range(0, 3) == 0);
        i_w_data     = (fifo_q.size() != 0) ? fifo_q[0] : 32'h0;
        m_axi_awready = rnd_mode ? ($urandom_range(0, 2) == 0) : 1'b1;
        m_axi_wready  = rnd_mode ? ($urandom_range(0, 1) == 1) : 1'b1;
        m_axi_bvalid  = b_pend && (rnd_mode ? ($urandom_range(0, 2) == 0) : 1'b1);
        m_axi_bresp   = (b_count == err_burst) ? 2'b10 : 2'b00;
        #1;
        if (m_axi_awvalid) begin
            awvalid_seen++;
            if (first_awv_cyc < 0) first_awv_cyc = cyc;
        end
        if (m_axi_wvalid) wvalid_seen++;
        if (prev_aw_wait && (!m_axi_awvalid || m_axi_awaddr !== prev_awaddr || m_axi_awlen !== prev_awlen))
            aw_unstable_err++;
        prev_aw_wait = m_axi_awvalid && !m_axi_awready;
        prev_awaddr  = m_axi_awaddr;
        prev_awlen   = m_axi_awlen;
        if (m_axi_awvalid && m_axi_awready) begin
            aw_addr_q.push_back(m_axi_awaddr);
            aw_len_q.push_back(m_axi_awlen);
            cur_len = m_axi_awlen;
            beat    = 0;
            aw_open = 1'b1;
        end
        if (o_fifo_pop && (!m_axi_wready || !m_axi_wvalid || i_fifo_empty)) pop_err++;
        if (m_axi_wvalid && !aw_open) w_order_err++;
        if (m_axi_wvalid && m_axi_wready) begin
            got_q.push_back(m_axi_wdata);
            if (m_axi_wlast !== (beat == int'(cur_len))) wlast_err++;
            if (m_axi_wlast) begin
                b_pend  = 1'b1;
                aw_open = 1'b0;
            end
            beat++;
        end
        if (o_fifo_pop && fifo_q.size() > 0) fifo_q.delete(0);
        if (m_axi_bvalid && m_axi_bready) begin
            b_pend = 1'b0;
            b_cyc  = cyc;
            b_count++;
        end
        if (o_write_done) begin
            done_cnt++;
            done_cyc = cyc;
        end
        cyc++;
    endtask

    // Issue one command and run until done (bounded), plus a few idle cycles.
    task automatic run_cmd(input logic [31:0] addr, input logic [31:0] len,
                           input int budget, input int glitch_off);
        aw_addr_q.delete(); aw_len_q.delete(); got_q.delete();
        done_cnt = 0; done_cyc = -1; b_cyc = -1; first_awv_cyc = -1;
        awvalid_seen = 0; wvalid_seen = 0; pop_err = 0; aw_unstable_err = 0;
        wlast_err = 0; w_order_err = 0; b_count = 0; beat = 0;
        b_pend = 1'b0; aw_open = 1'b0; prev_aw_wait = 1'b0;
        cmd_addr   = addr;
        cmd_len    = len;
        start_req  = 1'b1;
        start_cyc  = cyc;
        glitch_cyc = (glitch_off > 0) ? cyc + glitch_off : -1;
        step();
        start_req = 1'b0;
        for (int i = 0; i < budget && done_cnt == 0; i++) step();
        repeat (3) step();
    endtask

    task automatic chk_data(input string tag);
        int bad = 0;
        chk({tag, "_words"}, 64'(got_q.size()), 64'(exp_q.size()));
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
            if (got_q[i] !== exp_q[i]) bad++;
        chk({tag, "_data"}, 64'(bad), 64'd0);
    endtask

    task automatic chk_protocol(input string tag);
        chk({tag, "_pop_ok"}, 64'(pop_err), 64'd0);
        chk({tag, "_aw_stable"}, 64'(aw_unstable_err), 64'd0);
        chk({tag, "_wlast"}, 64'(wlast_err), 64'd0);
        chk({tag, "_w_after_aw"}, 64'(w_order_err), 64'd0);
        chk({tag, "_one_done"}, 64'(done_cnt), 64'd1);
    endtask

    task automatic fill(input int n, input logic [31:0] seed, input bit via_producer);
        exp_q.delete();
        for (int i = 0; i < n; i++) begin
            logic [31:0] w;
            w = (32'(i) * 32'h9E37_79B1) ^ seed;
            exp_q.push_back(w);
            if (via_producer) src_q.push_back(w);
            else              fifo_q.push_back(w);
        end
    endtask

    initial begin
        int bad_len;
        reset_n = 1'b0; i_start = 1'b0; i_dst_addr = 32'h0; i_total_len = 32'h0;
        i_fifo_empty = 1'b1; i_w_data = 32'h0; m_axi_awready = 1'b0;
        m_axi_wready = 1'b0; m_axi_bresp = 2'b00; m_axi_bvalid = 1'b0;

        // Reset state
        repeat (3) @(negedge clk);
        #1;
        chk("rst_awvalid", 64'(m_axi_awvalid), 64'd0);
        chk("rst_wvalid", 64'(m_axi_wvalid), 64'd0);
        chk("rst_bready", 64'(m_axi_bready), 64'd0);
        chk("rst_done", 64'(o_write_done), 64'd0);
        chk("rst_busy", 64'(o_busy), 64'd0);
        chk("rst_pop", 64'(o_fifo_pop), 64'd0);
        chk("rst_wlast", 64'(m_axi_wlast), 64'd0);
        chk("rst_awaddr", 64'(m_axi_awaddr), 64'd0);
        chk("rst_awlen", 64'(m_axi_awlen), 64'd0);
        chk("rst_awsize", 64'(m_axi_awsize), 64'h2);
        chk("rst_awburst", 64'(m_axi_awburst), 64'h1);
        chk("rst_wstrb", 64'(m_axi_wstrb), 64'hF);
        chk("rst_wr_err", 64'(o_wr_err), 64'd0);
        @(negedge clk);
        reset_n = 1'b1;

        // Basic: 16 words at 0xC000_0000, plus a stray i_start while busy
        fill(16, 32'h1111_0000, 1'b0);
        run_cmd(32'hC000_0000, 32'd64, 200, 6);
        chk("basic_aw_count", 64'(aw_addr_q.size()), 64'd1);
        chk("basic_awaddr", 64'(aw_addr_q[0]), 64'hC000_0000);
        chk("basic_awlen", 64'(aw_len_q[0]), 64'd15);
        chk("basic_aw_latency", 64'(first_awv_cyc - start_cyc), 64'd2);
        chk("basic_b_to_done", 64'(done_cyc - b_cyc), 64'd1);
        chk("basic_busy_after", 64'(o_busy), 64'd0);
        chk_data("basic");
        chk_protocol("basic");

        // 4 KB split: 0xC000_0FF0, 16 words -> 4 + 12
        fill(16, 32'h2222_0000, 1'b0);
        run_cmd(32'hC000_0FF0, 32'd64, 200, 0);
        chk("split_aw_count", 64'(aw_addr_q.size()), 64'd2);
        chk("split_addr0", 64'(aw_addr_q[0]), 64'hC000_0FF0);
        chk("split_len0", 64'(aw_len_q[0]), 64'd3);
        chk("split_addr1", 64'(aw_addr_q[1]), 64'hC000_1000);
        chk("split_len1", 64'(aw_len_q[1]), 64'd11);
        chk_data("split");
        chk_protocol("split");

        // Zero length: done two cycles after start, no AXI activity
        run_cmd(32'hC000_0100, 32'd0, 20, 0);
        chk("len0_latency", 64'(done_cyc - start_cyc), 64'd2);
        chk("len0_awvalid", 64'(awvalid_seen), 64'd0);
        chk("len0_wvalid", 64'(wvalid_seen), 64'd0);
        chk("len0_one_done", 64'(done_cnt), 64'd1);

        // Backpressure: 50 words from 0x0F80 -> bursts 16,16 (to 4K), 16, 2
        rnd_mode = 1'b1;
        fill(50, 32'h3333_0000, 1'b1);
        run_cmd(32'h0000_0F80, 32'd200, 3000, 0);
        rnd_mode = 1'b0;
        chk("bp_aw_count", 64'(aw_addr_q.size()), 64'd4);
        chk("bp_addr1", 64'(aw_addr_q[1]), 64'h0000_0FC0);
        chk("bp_addr3", 64'(aw_addr_q[3]), 64'h0000_1040);
        chk("bp_len2", 64'(aw_len_q[2]), 64'd15);
        chk("bp_len3", 64'(aw_len_q[3]), 64'd1);
        chk_data("bp");
        chk_protocol("bp");

        // Reset mid-W: only 4 of 16 words available, then reset_n pulse
        fill(4, 32'h4444_0000, 1'b0);
        run_cmd(32'h4000_0000, 32'd64, 12, 0);
        chk("midw_words", 64'(got_q.size()), 64'd4);
        chk("midw_busy", 64'(o_busy), 64'd1);
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        chk("midw_rst_awvalid", 64'(m_axi_awvalid), 64'd0);
        chk("midw_rst_wvalid", 64'(m_axi_wvalid), 64'd0);
        chk("midw_rst_bready", 64'(m_axi_bready), 64'd0);
        chk("midw_rst_busy", 64'(o_busy), 64'd0);
        @(negedge clk);
        reset_n = 1'b1;
        fifo_q.delete();
        fill(8, 32'h5555_0000, 1'b0);
        run_cmd(32'h3000_0000, 32'd32, 200, 0);
        chk("after_rst_awaddr", 64'(aw_addr_q[0]), 64'h3000_0000);
        chk("after_rst_awlen", 64'(aw_len_q[0]), 64'd7);
        chk_data("after_rst");
        chk_protocol("after_rst");

        // Multi-burst: 64 KB, 1024 bursts of 16
        fill(16384, 32'h6666_0000, 1'b0);
        run_cmd(32'hC000_0000, 32'd65536, 40000, 0);
        bad_len = 0;
        foreach (aw_len_q[i]) if (aw_len_q[i] !== 8'd15) bad_len++;
        chk("multi_aw_count", 64'(aw_addr_q.size()), 64'd1024);
        chk("multi_lens", 64'(bad_len), 64'd0);
        chk("multi_last_addr", 64'(aw_addr_q[1023]), 64'hC000_FFC0);
        chk_data("multi");
        chk_protocol("multi");

`ifdef DMA_WR_BRESP_CHECK_EN
        // SLVERR on burst 2 of 3: flag sticks, transfer completes, start clears
        err_burst = 1;
        fill(48, 32'h7777_0000, 1'b0);
        run_cmd(32'h5000_0000, 32'd192, 400, 0);
        err_burst = -1;
        chk("err_aw_count", 64'(aw_addr_q.size()), 64'd3);
        chk("err_flag", 64'(o_wr_err), 64'd1);
        chk_data("err");
        run_cmd(32'h5000_0000, 32'd0, 20, 0);
        chk("err_cleared", 64'(o_wr_err), 64'd0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
